t10_keypad_fsm: RTL
===================

# t10_keypad_fsm

Sequencer for the 4x4 keypad scanner: paces scanning, debounces `strobe`/`cur_key`, and decodes the one-hot `{row,col}` key code. It builds a BCD operand buffer from digit keys and issues operator/enter events downstream with a valid/ready handshake. It sits between the keypad scanner and the calculator datapath.

## Interface
- `SCAN_DIV`, default 1000: clk cycles per scan tick (≥2).
- `DEBOUNCE`, default 4: consecutive scan ticks for press/release acceptance (≥1).
- `DIGITS`, default 4: operand buffer depth in BCD digits (≥1).
- `REPEAT_DLY`, default 250: scan ticks per auto-repeat (macro only).
- `clk`  in  1  clock
- `nRst`  in  1  reset, asynchronous, active-low
- `active`  in  1  block enable; drives scanner mode
- `strobe`  in  1  scanner key-present flag
- `cur_key`  in  8  `{row[3:0], col[3:0]}`, each one-hot, 0 = none
- `scan_mode`  out  1  equals registered `active`
- `scan_en`  out  1  one-cycle scan tick to scanner enable
- `digit_buf`  out  4*DIGITS  BCD operand, newest digit in low nibble
- `digit_cnt`  out  $clog2(DIGITS+1)  digits held
- `evt_valid`  out  1  event pending
- `evt_code`  out  4  A=0xA, B=0xB, C=0xC, D=0xD, #=0xE
- `evt_ready`  in  1  downstream accepts event
- `overflow`  out  1  one-cycle pulse, digit rejected (buffer full)

## Operation
- Key map (row[3] top, col[3] left):
  - 1 2 3 A
  - 4 5 6 B
  - 7 8 9 C
  - \* 0 # D
- Example codes: `8'h88`='1', `8'h44`='5', `8'h14`='0', `8'h18`='\*', `8'h12`='#', `8'h11`='D'.
- Codes with a non-one-hot row or column are invalid and treated as no key.
- States and transitions:
  - IDLE → DEB_PRESS: on a tick with `strobe` high and a valid key; latch the key.
  - DEB_PRESS: counts ticks with the same key. Reaching DEBOUNCE → ACCEPT. A different or absent key → IDLE.
  - ACCEPT (1 cycle): acts on the key, then → HELD.
  - HELD → DEB_REL: on a tick with `strobe` low.
  - DEB_REL: counts no-key ticks. Reaching DEBOUNCE → IDLE. Any key present → HELD.
- Digit 0–9: if `digit_cnt<DIGITS`, shift `digit_buf` left 4 bits, insert the digit, increment the count. Otherwise pulse `overflow` and leave the buffer unchanged.
- '\*': clear `digit_buf` and `digit_cnt`.
- A–D and '#': set `evt_valid`/`evt_code`.
  - `evt_valid` holds with `evt_code` stable until the cycle `evt_ready` is high.
  - In that handshake cycle, `digit_buf` and `digit_cnt` clear.
- While `evt_valid` is high, ACCEPT performs no action and the key is discarded. The FSM still tracks release.
- `active` low:
  - `scan_en` is forced 0 and the tick counter holds at 0.
  - The FSM goes to IDLE next cycle.
  - A pending event stays valid until accepted.
  - `digit_buf` is preserved.

## Timing
- Reset values: all outputs 0, FSM IDLE, tick counter 0.
- `scan_en` pulses when the tick counter equals SCAN_DIV-1, then the counter wraps to 0.
  - First pulse comes SCAN_DIV cycles after `active` rises.
- Press latency: ACCEPT occurs the cycle after the DEBOUNCE-th qualifying tick. Buffer and `evt_valid` update at the end of ACCEPT.
- Same-cycle handshake and ACCEPT cannot coincide: ACCEPT is suppressed while `evt_valid` is high.
- `overflow` is high only during the ACCEPT cycle.
- Asynchronous reset mid-debounce or mid-event clears everything, including a pending event.

## Configuration
- `T10_KEYPAD_AUTOREPEAT_EN` defined: in HELD, with a digit key latched and no pending event, a repeat counter counts ticks. Every REPEAT_DLY ticks it re-performs the digit action, including the overflow rule. The counter resets on entering HELD and when going from DEB_REL back to HELD.
- Undefined: exactly one action per press. No repeat counter is synthesized.

## Structure
- `t10_keypad_pkg`:
  - state enum `keypad_state_t`
  - key-code constants
  - event codes `EVT_A`..`EVT_ENTER`
  - decoded key-class enum: digit / clear / event / none
- Sub-module `t10_keypad_decode`: combinational `cur_key` → {class, 4-bit value}, including the one-hot validity check.

## Test plan
- With SCAN_DIV=4 and `active` high, count `scan_en` over 40 cycles → 10 pulses, each 4 cycles apart.
- Hold `8'h44` for DEBOUNCE ticks, then release → `digit_buf`=0x0005, `digit_cnt`=1, no `overflow`.
- Press 1,2,3,4,5 with DIGITS=4 → `digit_buf`=0x1234, `digit_cnt`=4; the fifth press pulses `overflow` once.
- Bounce: key present for DEBOUNCE-1 ticks, absent one tick, repeated → buffer unchanged.
- Press '#' with `evt_ready` low for 10 cycles, press '7' meanwhile, then raise `evt_ready`:
  - `evt_code`=0xE held throughout.
  - '7' ignored.
  - Buffer clears in the handshake cycle.
- Assert `nRst` during DEB_PRESS with `evt_valid` high → all outputs 0 immediately, FSM IDLE.

Source files
------------

// File: rtl/t10_keypad_pkg.sv
// Keypad sequencer shared types: FSM states, key classes, key codes, event codes.
// No logic; is_onehot4() is a combinational helper used by the key decoder.
// Key codes are {row[3:0], col[3:0]}; row[3] is the top row, col[3] the left column.
package t10_keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_ACCEPT,
    ST_HELD,
    ST_DEB_REL
  } keypad_state_t;

  typedef enum logic [1:0] {
    KC_NONE,
    KC_DIGIT,
    KC_CLEAR,
    KC_EVENT
  } key_class_t;

  localparam logic [7:0] KEY_1    = 8'h88;
  localparam logic [7:0] KEY_2    = 8'h84;
  localparam logic [7:0] KEY_3    = 8'h82;
  localparam logic [7:0] KEY_A    = 8'h81;
  localparam logic [7:0] KEY_4    = 8'h48;
  localparam logic [7:0] KEY_5    = 8'h44;
  localparam logic [7:0] KEY_6    = 8'h42;
  localparam logic [7:0] KEY_B    = 8'h41;
  localparam logic [7:0] KEY_7    = 8'h28;
  localparam logic [7:0] KEY_8    = 8'h24;
  localparam logic [7:0] KEY_9    = 8'h22;
  localparam logic [7:0] KEY_C    = 8'h21;
  localparam logic [7:0] KEY_STAR = 8'h18;
  localparam logic [7:0] KEY_0    = 8'h14;
  localparam logic [7:0] KEY_HASH = 8'h12;
  localparam logic [7:0] KEY_D    = 8'h11;

  localparam logic [3:0] EVT_A     = 4'hA;
  localparam logic [3:0] EVT_B     = 4'hB;
  localparam logic [3:0] EVT_C     = 4'hC;
  localparam logic [3:0] EVT_D     = 4'hD;
  localparam logic [3:0] EVT_ENTER = 4'hE;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/t10_keypad_if.sv
// Operator/enter event channel from the keypad sequencer to the calculator datapath.
// Signals: evt_valid (event pending), evt_code (4-bit event), evt_ready (sink accepts).
// Valid/ready: the source holds valid and code stable until the cycle ready is high.
interface t10_keypad_if;
  logic       evt_valid;
  logic [3:0] evt_code;
  logic       evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/t10_keypad_decode.sv
// Combinational keypad decoder: key -> {class, value}; non-one-hot row/col is KC_NONE.
// Latency 0. No backpressure.
// Ports: key (8-bit {row,col}) in; cls (key_class_t), val (digit 0-9 or event code) out.
module t10_keypad_decode import t10_keypad_pkg::*; (
  input  logic [7:0] key,
  output key_class_t cls,
  output logic [3:0] val
);

  always_comb begin
    cls = KC_NONE;
    val = 4'd0;
    if (is_onehot4(key[7:4]) && is_onehot4(key[3:0])) begin
      case (key)
        KEY_1:    begin cls = KC_DIGIT; val = 4'd1;      end
        KEY_2:    begin cls = KC_DIGIT; val = 4'd2;      end
        KEY_3:    begin cls = KC_DIGIT; val = 4'd3;      end
        KEY_4:    begin cls = KC_DIGIT; val = 4'd4;      end
        KEY_5:    begin cls = KC_DIGIT; val = 4'd5;      end
        KEY_6:    begin cls = KC_DIGIT; val = 4'd6;      end
        KEY_7:    begin cls = KC_DIGIT; val = 4'd7;      end
        KEY_8:    begin cls = KC_DIGIT; val = 4'd8;      end
        KEY_9:    begin cls = KC_DIGIT; val = 4'd9;      end
        KEY_0:    begin cls = KC_DIGIT; val = 4'd0;      end
        KEY_STAR: begin cls = KC_CLEAR; val = 4'd0;      end
        KEY_A:    begin cls = KC_EVENT; val = EVT_A;     end
        KEY_B:    begin cls = KC_EVENT; val = EVT_B;     end
        KEY_C:    begin cls = KC_EVENT; val = EVT_C;     end
        KEY_D:    begin cls = KC_EVENT; val = EVT_D;     end
        KEY_HASH: begin cls = KC_EVENT; val = EVT_ENTER; end
        default:  begin cls = KC_NONE;  val = 4'd0;      end
      endcase
    end
  end

endmodule

// File: rtl/t10_keypad_fsm.sv
// Keypad sequencer: paces the scanner, debounces presses/releases, builds a BCD operand, issues events.
// Latency: a key acts the cycle after its DEBOUNCE-th qualifying scan tick (ACCEPT), results visible next cycle.
// Backpressure: a pending event holds until evt_ready; keys accepted meanwhile are discarded.
// Ports: clk, nRst (async, active-low), active, strobe, cur_key in; scan_mode, scan_en, digit_buf,
//        digit_cnt, overflow out; evt (t10_keypad_if.master) event channel.
// Option: define T10_KEYPAD_AUTOREPEAT_EN to repeat a held digit every REPEAT_DLY scan ticks.
module t10_keypad_fsm import t10_keypad_pkg::*; #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int DIGITS   = 4
`ifdef T10_KEYPAD_AUTOREPEAT_EN
  , parameter int REPEAT_DLY = 250
`endif
) (
  input  logic                           clk,
  input  logic                           nRst,
  input  logic                           active,
  input  logic                           strobe,
  input  logic [7:0]                     cur_key,
  output logic                           scan_mode,
  output logic                           scan_en,
  output logic [4*DIGITS-1:0]            digit_buf,
  output logic [$clog2(DIGITS+1)-1:0]    digit_cnt,
  output logic                           overflow,
  t10_keypad_if.master                   evt
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int BUF_W = 4 * DIGITS;

  // Scan pacing
  logic [DIV_W-1:0] div_cnt;
  logic             scan_en_q;
  logic             active_q;
  logic             tick;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      active_q  <= 1'b0;
      div_cnt   <= '0;
      scan_en_q <= 1'b0;
    end else begin
      active_q <= active;
      if (active) begin
        if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
          div_cnt   <= '0;
          scan_en_q <= 1'b1;
        end else begin
          div_cnt   <= div_cnt + DIV_W'(1);
          scan_en_q <= 1'b0;
        end
      end else begin
        div_cnt   <= '0;
        scan_en_q <= 1'b0;
      end
    end
  end

  // Gate with the live input so a tick already registered is dropped the moment active falls.
  assign tick      = scan_en_q && active;
  assign scan_en   = tick;
  assign scan_mode = active_q;

  // Key decode and press/release FSM
  key_class_t    cur_cls;
  logic [3:0]    cur_val;
  keypad_state_t state, state_d;
  logic [DEB_W-1:0] deb_cnt, deb_d;
  logic [7:0]    key_q, key_d;
  key_class_t    held_cls, held_cls_d;
  logic [3:0]    held_val, held_val_d;

  t10_keypad_decode u_decode (
    .key (cur_key),
    .cls (cur_cls),
    .val (cur_val)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= ST_IDLE;
      deb_cnt  <= '0;
      key_q    <= '0;
      held_cls <= KC_NONE;
      held_val <= '0;
    end else begin
      state    <= state_d;
      deb_cnt  <= deb_d;
      key_q    <= key_d;
      held_cls <= held_cls_d;
      held_val <= held_val_d;
    end
  end

  // The tick that first sees the key (or its absence) counts as the first of DEBOUNCE.
  always_comb begin
    state_d    = state;
    deb_d      = deb_cnt;
    key_d      = key_q;
    held_cls_d = held_cls;
    held_val_d = held_val;
    case (state)
      ST_IDLE: begin
        if (tick && strobe && (cur_cls != KC_NONE)) begin
          key_d      = cur_key;
          held_cls_d = cur_cls;
          held_val_d = cur_val;
          deb_d      = DEB_W'(1);
          state_d    = (DEBOUNCE == 1) ? ST_ACCEPT : ST_DEB_PRESS;
        end
      end
      ST_DEB_PRESS: begin
        if (tick) begin
          if (strobe && (cur_key == key_q)) begin
            if (deb_cnt == DEB_W'(DEBOUNCE - 1)) state_d = ST_ACCEPT;
            else                                  deb_d   = deb_cnt + DEB_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ACCEPT: state_d = ST_HELD;
      ST_HELD: begin
        if (tick && !strobe) begin
          deb_d   = DEB_W'(1);
          state_d = (DEBOUNCE == 1) ? ST_IDLE : ST_DEB_REL;
        end
      end
      ST_DEB_REL: begin
        if (tick) begin
          if (strobe)                                state_d = ST_HELD;
          else if (deb_cnt == DEB_W'(DEBOUNCE - 1))  state_d = ST_IDLE;
          else                                       deb_d   = deb_cnt + DEB_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!active) state_d = ST_IDLE;
  end

  // Key actions
  logic             evt_valid_q;
  logic [3:0]       evt_code_q;
  logic             accept_act;
  logic             digit_fire;
  logic             buf_full;
  logic             rpt_fire;
  logic [BUF_W-1:0] buf_shift;

`ifdef T10_KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DLY + 1);
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_run;

  // Only ticks that still see the key held count toward a repeat.
  assign rpt_run  = (state == ST_HELD) && (held_cls == KC_DIGIT) && !evt_valid_q && tick && strobe;
  assign rpt_fire = rpt_run && (rpt_cnt == RPT_W'(REPEAT_DLY - 1));

  // Cleared outside HELD, so it restarts on every entry (from ACCEPT or from DEB_REL).
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)                  rpt_cnt <= '0;
    else if (state != ST_HELD)  rpt_cnt <= '0;
    else if (rpt_fire)          rpt_cnt <= '0;
    else if (rpt_run)           rpt_cnt <= rpt_cnt + RPT_W'(1);
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign accept_act = (state == ST_ACCEPT) && !evt_valid_q;
  assign digit_fire = (accept_act && (held_cls == KC_DIGIT)) || rpt_fire;
  assign buf_full   = (digit_cnt == CNT_W'(DIGITS));
  assign overflow   = digit_fire && buf_full;

  always_comb begin
    buf_shift      = digit_buf << 4;
    buf_shift[3:0] = held_val;
  end

  // Handshake and key actions never coincide: every action requires no pending event.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      digit_buf   <= '0;
      digit_cnt   <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
    end else if (evt_valid_q && evt.evt_ready) begin
      evt_valid_q <= 1'b0;
      digit_buf   <= '0;
      digit_cnt   <= '0;
    end else if (digit_fire && !buf_full) begin
      digit_buf <= buf_shift;
      digit_cnt <= digit_cnt + CNT_W'(1);
    end else if (accept_act && (held_cls == KC_CLEAR)) begin
      digit_buf <= '0;
      digit_cnt <= '0;
    end else if (accept_act && (held_cls == KC_EVENT)) begin
      evt_valid_q <= 1'b1;
      evt_code_q  <= held_val;
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_code  = evt_code_q;

endmodule
